// File: rtl/noc_packetizer_if.sv
// Request, payload and flit-output handshake bundle for noc_packetizer.
// The packetizer itself connects through the slave modport.
interface noc_packetizer_if #(
  parameter int COORD_W = 4,
  parameter int LEN_W   = 4,
  parameter int FLIT_W  = 32
);
  logic               req_valid;
  logic               req_ready;
  logic [COORD_W-1:0] req_dst_x;
  logic [COORD_W-1:0] req_dst_y;
  logic [LEN_W-1:0]   req_len;
  logic               pay_valid;
  logic               pay_ready;
  logic [FLIT_W-1:0]  pay_data;
  logic               flit_valid;
  logic               flit_ready;
  logic [1:0]         flit_type;
  logic [FLIT_W-1:0]  flit_data;

  modport slave (
    input  req_valid, req_dst_x, req_dst_y, req_len, pay_valid, pay_data, flit_ready,
    output req_ready, pay_ready, flit_valid, flit_type, flit_data
  );

  modport master (
    output req_valid, req_dst_x, req_dst_y, req_len, pay_valid, pay_data, flit_ready,
    input  req_ready, pay_ready, flit_valid, flit_type, flit_data
  );
endinterface

// File: rtl/noc_packetizer.sv
// Builds NoC packets: one head flit carrying routing info, then req_len payload
// flits, driven from a single output register onto the fabric local port.
module noc_packetizer #(
  parameter int X_ID    = 0,
  parameter int Y_ID    = 0,
  parameter int COORD_W = 4,
  parameter int LEN_W   = 4,
  parameter int FLIT_W  = 32
) (
  input  logic               noc_clk,
  input  logic               noc_rst,
  noc_packetizer_if.slave    bus,
  output logic               busy,
  output logic [15:0]        pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } state_t;

  localparam logic [1:0] T_BODY      = 2'b00;
  localparam logic [1:0] T_HEAD      = 2'b01;
  localparam logic [1:0] T_TAIL      = 2'b10;
  localparam logic [1:0] T_HEAD_TAIL = 2'b11;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [7:0]          pkt_id_q, pkt_id_d;
  logic [15:0]         pkt_cnt_q, pkt_cnt_d;
  logic                flit_valid_q, flit_valid_d;
  logic [1:0]          flit_type_q, flit_type_d;
  logic [FLIT_W-1:0]   flit_data_q, flit_data_d;

  logic                flit_acc;
  logic                pay_hs;
  logic [FLIT_W-1:0]   head_data;

  always_comb begin
    head_data = '0;
    head_data[0*COORD_W +: COORD_W]    = bus.req_dst_x;
    head_data[1*COORD_W +: COORD_W]    = bus.req_dst_y;
    head_data[2*COORD_W +: COORD_W]    = COORD_W'(X_ID);
    head_data[3*COORD_W +: COORD_W]    = COORD_W'(Y_ID);
    head_data[4*COORD_W +: LEN_W]      = bus.req_len;
    head_data[4*COORD_W + LEN_W +: 8]  = pkt_id_q;
  end

  assign flit_acc      = flit_valid_q && bus.flit_ready;
  assign bus.pay_ready = (state_q != IDLE) && (rem_q != '0) && (!flit_valid_q || bus.flit_ready);
  assign pay_hs        = bus.pay_valid && bus.pay_ready;

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    pkt_id_d     = pkt_id_q;
    pkt_cnt_d    = pkt_cnt_q;
    flit_valid_d = flit_valid_q;
    flit_type_d  = flit_type_q;
    flit_data_d  = flit_data_q;

    if (state_q == IDLE) begin
      if (bus.req_valid) begin
        flit_valid_d = 1'b1;
        flit_data_d  = head_data;
        flit_type_d  = (bus.req_len == '0) ? T_HEAD_TAIL : T_HEAD;
        rem_d        = bus.req_len;
        state_d      = HEAD;
      end
    end else begin
      // A payload word may replace the flit leaving this cycle; otherwise the
      // register empties so nothing is sent twice.
      if (pay_hs) begin
        flit_valid_d = 1'b1;
        flit_data_d  = bus.pay_data;
        flit_type_d  = (rem_q == LEN_W'(1)) ? T_TAIL : T_BODY;
        rem_d        = rem_q - LEN_W'(1);
      end else if (flit_acc) begin
        flit_valid_d = 1'b0;
      end

      if (flit_acc) begin
        if (flit_type_q[1]) begin
          state_d   = IDLE;
          pkt_id_d  = pkt_id_q + 8'd1;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end else if (state_q == HEAD) begin
          state_d = BODY;
        end
      end
    end
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      pkt_id_q     <= '0;
      pkt_cnt_q    <= '0;
      flit_valid_q <= 1'b0;
      flit_type_q  <= T_BODY;
      flit_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      pkt_id_q     <= pkt_id_d;
      pkt_cnt_q    <= pkt_cnt_d;
      flit_valid_q <= flit_valid_d;
      flit_type_q  <= flit_type_d;
      flit_data_q  <= flit_data_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.flit_valid = flit_valid_q;
  assign bus.flit_type  = flit_type_q;
  assign bus.flit_data  = flit_data_q;
  assign busy           = (state_q != IDLE);
  assign pkt_cnt        = pkt_cnt_q;

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed bench for noc_packetizer with X_ID=1, Y_ID=2 and default widths.
module tb_noc_packetizer;
  logic        clk;
  logic        rst;
  logic        busy;
  logic [15:0] pkt_cnt;
  int          checks;
  int          errors;
  logic [33:0] mon[$];

  noc_packetizer_if #(.COORD_W(4), .LEN_W(4), .FLIT_W(32)) bus ();

  noc_packetizer #(.X_ID(1), .Y_ID(2), .COORD_W(4), .LEN_W(4), .FLIT_W(32)) dut (
    .noc_clk (clk),
    .noc_rst (rst),
    .bus     (bus),
    .busy    (busy),
    .pkt_cnt (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && bus.flit_valid && bus.flit_ready) mon.push_back({bus.flit_type, bus.flit_data});

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [3:0] x, input logic [3:0] y, input logic [3:0] len);
    bus.req_valid = 1'b1;
    bus.req_dst_x = x;
    bus.req_dst_y = y;
    bus.req_len   = len;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.pay_valid = 1'b1;
    bus.pay_data  = 32'hDEAD_BEEF;
    tick; tick;
    checks++; if (bus.flit_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", bus.flit_valid); end
    checks++; if (bus.flit_type !== 2'b00) begin errors++; $display("FAIL rst_type got %0b exp 00", bus.flit_type); end
    checks++; if (bus.flit_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", bus.flit_data); end
    checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", pkt_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
    rst = 1'b0;
    tick;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %0b exp 1", bus.req_ready); end
    checks++; if (bus.pay_ready !== 1'b0) begin errors++; $display("FAIL idle_pay_ready got %0b exp 0", bus.pay_ready); end
    tick;
    checks++; if (bus.flit_valid !== 1'b0) begin errors++; $display("FAIL idle_pay_ignored got %0b exp 0", bus.flit_valid); end
    bus.pay_valid = 1'b0;
  endtask

  task automatic test_head_tail;
    request(4'd3, 4'd0, 4'd0);
    tick;
    bus.req_valid = 1'b0;
    checks++; if (bus.flit_valid !== 1'b1) begin errors++; $display("FAIL ht_valid got %0b exp 1", bus.flit_valid); end
    checks++; if (bus.flit_type !== 2'b11) begin errors++; $display("FAIL ht_type got %0b exp 11", bus.flit_type); end
    checks++; if (bus.flit_data !== 32'h0000_2103) begin errors++; $display("FAIL ht_data got %h exp 00002103", bus.flit_data); end
    checks++; if (bus.req_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ht_busy got rdy %0b busy %0b exp 0 1", bus.req_ready, busy); end
    tick;
    checks++; if (bus.flit_valid !== 1'b0) begin errors++; $display("FAIL ht_drop got %0b exp 0", bus.flit_valid); end
    checks++; if (pkt_cnt !== 16'd1 || busy !== 1'b0) begin errors++; $display("FAIL ht_cnt got cnt %0d busy %0b exp 1 0", pkt_cnt, busy); end
  endtask

  task automatic test_back_to_back;
    request(4'd5, 4'd6, 4'd3);
    tick;
    bus.req_valid = 1'b0;
    checks++; if (bus.flit_type !== 2'b01 || bus.flit_data !== 32'h0013_2165) begin errors++; $display("FAIL b2b_head got %b %h exp 01 00132165", bus.flit_type, bus.flit_data); end
    checks++; if (bus.pay_ready !== 1'b1) begin errors++; $display("FAIL b2b_pay_ready got %0b exp 1", bus.pay_ready); end
    bus.pay_valid = 1'b1; bus.pay_data = 32'hAAAA_0001;
    tick;
    checks++; if (bus.flit_valid !== 1'b1 || bus.flit_type !== 2'b00 || bus.flit_data !== 32'hAAAA_0001) begin errors++; $display("FAIL b2b_A got %b %b %h exp 1 00 aaaa0001", bus.flit_valid, bus.flit_type, bus.flit_data); end
    bus.pay_data = 32'hBBBB_0002;
    tick;
    checks++; if (bus.flit_valid !== 1'b1 || bus.flit_type !== 2'b00 || bus.flit_data !== 32'hBBBB_0002) begin errors++; $display("FAIL b2b_B got %b %b %h exp 1 00 bbbb0002", bus.flit_valid, bus.flit_type, bus.flit_data); end
    bus.pay_data = 32'hCCCC_0003;
    tick;
    checks++; if (bus.flit_valid !== 1'b1 || bus.flit_type !== 2'b10 || bus.flit_data !== 32'hCCCC_0003) begin errors++; $display("FAIL b2b_C got %b %b %h exp 1 10 cccc0003", bus.flit_valid, bus.flit_type, bus.flit_data); end
    checks++; if (bus.pay_ready !== 1'b0 || bus.req_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_tail_ctrl got pr %0b rr %0b busy %0b exp 0 0 1", bus.pay_ready, bus.req_ready, busy); end
    bus.pay_valid = 1'b0;
    tick;
    checks++; if (busy !== 1'b0 || bus.flit_valid !== 1'b0 || pkt_cnt !== 16'd2) begin errors++; $display("FAIL b2b_end got busy %0b v %0b cnt %0d exp 0 0 2", busy, bus.flit_valid, pkt_cnt); end
  endtask

  task automatic test_stall;
    bus.flit_ready = 1'b0;
    request(4'd1, 4'd1, 4'd2);
    tick;
    bus.req_valid = 1'b0;
    bus.pay_valid = 1'b1; bus.pay_data = 32'hD000_000D;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.flit_valid !== 1'b1 || bus.flit_type !== 2'b01 || bus.flit_data !== 32'h0022_2111) begin errors++; $display("FAIL stall_head[%0d] got %b %b %h exp 1 01 00222111", i, bus.flit_valid, bus.flit_type, bus.flit_data); end
      checks++; if (bus.pay_ready !== 1'b0) begin errors++; $display("FAIL stall_pay_ready[%0d] got %0b exp 0", i, bus.pay_ready); end
      if (i < 4) tick;
    end
    bus.flit_ready = 1'b1;
    #1;
    checks++; if (bus.pay_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %0b exp 1", bus.pay_ready); end
    tick;
    checks++; if (bus.flit_type !== 2'b00 || bus.flit_data !== 32'hD000_000D) begin errors++; $display("FAIL stall_D got %b %h exp 00 d000000d", bus.flit_type, bus.flit_data); end
    bus.pay_data = 32'hE000_000E;
    tick;
    checks++; if (bus.flit_type !== 2'b10 || bus.flit_data !== 32'hE000_000E) begin errors++; $display("FAIL stall_E got %b %h exp 10 e000000e", bus.flit_type, bus.flit_data); end
    bus.pay_valid = 1'b0;
    tick;
    checks++; if (pkt_cnt !== 16'd3 || busy !== 1'b0) begin errors++; $display("FAIL stall_end got cnt %0d busy %0b exp 3 0", pkt_cnt, busy); end
  endtask

  task automatic test_gaps;
    mon.delete();
    request(4'd2, 4'd3, 4'd2);
    tick;
    bus.req_valid = 1'b0;
    tick;
    checks++; if (bus.flit_valid !== 1'b0) begin errors++; $display("FAIL gap_bubble1 got %0b exp 0", bus.flit_valid); end
    tick;
    bus.pay_valid = 1'b1; bus.pay_data = 32'h1111_1111;
    tick;
    bus.pay_valid = 1'b0;
    checks++; if (bus.flit_valid !== 1'b1 || bus.flit_type !== 2'b00) begin errors++; $display("FAIL gap_w1 got %b %b exp 1 00", bus.flit_valid, bus.flit_type); end
    tick;
    checks++; if (bus.flit_valid !== 1'b0) begin errors++; $display("FAIL gap_bubble2 got %0b exp 0", bus.flit_valid); end
    tick;
    bus.pay_valid = 1'b1; bus.pay_data = 32'h2222_2222;
    tick;
    bus.pay_valid = 1'b0;
    checks++; if (bus.flit_valid !== 1'b1 || bus.flit_type !== 2'b10) begin errors++; $display("FAIL gap_w2 got %b %b exp 1 10", bus.flit_valid, bus.flit_type); end
    tick;
    checks++; if (mon.size() !== 3) begin errors++; $display("FAIL gap_count got %0d exp 3", mon.size()); end
    else begin
      checks++; if (mon[0] !== {2'b01, 32'h0032_2132}) begin errors++; $display("FAIL gap_mon0 got %h exp 1_00322132", mon[0]); end
      checks++; if (mon[1] !== {2'b00, 32'h1111_1111}) begin errors++; $display("FAIL gap_mon1 got %h exp 0_11111111", mon[1]); end
      checks++; if (mon[2] !== {2'b10, 32'h2222_2222}) begin errors++; $display("FAIL gap_mon2 got %h exp 2_22222222", mon[2]); end
    end
    checks++; if (pkt_cnt !== 16'd4) begin errors++; $display("FAIL gap_cnt got %0d exp 4", pkt_cnt); end
  endtask

  task automatic test_wrap;
    repeat (252) begin
      request(4'd0, 4'd0, 4'd0);
      tick;
      bus.req_valid = 1'b0;
      tick;
    end
    checks++; if (pkt_cnt !== 16'd256) begin errors++; $display("FAIL wrap_cnt got %0d exp 256", pkt_cnt); end
    request(4'd0, 4'd0, 4'd0);
    tick;
    bus.req_valid = 1'b0;
    checks++; if (bus.flit_type !== 2'b11 || bus.flit_data !== 32'h0000_2100) begin errors++; $display("FAIL wrap_head got %b %h exp 11 00002100", bus.flit_type, bus.flit_data); end
    tick;
    checks++; if (pkt_cnt !== 16'd257) begin errors++; $display("FAIL wrap_cnt2 got %0d exp 257", pkt_cnt); end
  endtask

  task automatic test_reset_abort;
    request(4'd4, 4'd4, 4'd4);
    tick;
    bus.req_valid = 1'b0;
    checks++; if (bus.flit_data !== 32'h0014_2144) begin errors++; $display("FAIL abort_head got %h exp 00142144", bus.flit_data); end
    bus.pay_valid = 1'b1; bus.pay_data = 32'h5000_0000;
    tick;
    bus.pay_data = 32'h5000_0001;
    tick;
    checks++; if (bus.flit_type !== 2'b00 || bus.flit_data !== 32'h5000_0001) begin errors++; $display("FAIL abort_body2 got %b %h exp 00 50000001", bus.flit_type, bus.flit_data); end
    rst = 1'b1;
    bus.pay_valid = 1'b0;
    tick;
    rst = 1'b0;
    checks++; if (bus.flit_valid !== 1'b0 || pkt_cnt !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL abort_state got v %0b cnt %0d busy %0b exp 0 0 0", bus.flit_valid, pkt_cnt, busy); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL abort_req_ready got %0b exp 1", bus.req_ready); end
    request(4'd7, 4'd7, 4'd0);
    tick;
    bus.req_valid = 1'b0;
    checks++; if (bus.flit_type !== 2'b11 || bus.flit_data !== 32'h0000_2177) begin errors++; $display("FAIL abort_new_head got %b %h exp 11 00002177", bus.flit_type, bus.flit_data); end
    tick;
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL abort_new_cnt got %0d exp 1", pkt_cnt); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_dst_x  = '0;
    bus.req_dst_y  = '0;
    bus.req_len    = '0;
    bus.pay_valid  = 1'b0;
    bus.pay_data   = '0;
    bus.flit_ready = 1'b1;
    test_reset;
    test_head_tail;
    test_back_to_back;
    test_stall;
    test_gaps;
    test_wrap;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
